// File: rtl/ad5676r_ch_scheduler.sv
// Eight-channel AD5676R update scheduler: holds per-channel codes and issues round-robin write/update frames.
// Optional feature macro AD5676R_INIT_SEQ_EN: software-reset frame and full-channel rewrite after reset.
module ad5676r_ch_scheduler #(
    parameter int NUM_CH       = 8,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_inv,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [15:0]       wr_code,
    output logic [23:0]       frm_data,
    output logic              frm_valid,
    input  logic              frm_ready,
    input  logic              frm_done,
    output logic              busy,
    output logic [NUM_CH-1:0] pending,
    output logic              err_timeout
);

    localparam logic [7:0]  TO_LAST     = 8'(DONE_TIMEOUT - 1);
    localparam logic [23:0] RESET_FRAME = 24'h600000;

    typedef enum logic [1:0] {IDLE, PICK, SEND, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       code [NUM_CH];
    logic [NUM_CH-1:0] dirty;
    logic [NUM_CH-1:0] dirty_nxt;
    logic [2:0]        rr;
    logic [7:0]        cnt;
    logic              pick_found;
    logic [2:0]        pick_ch;
    logic [2:0]        idx;
    logic              init_req;
    logic              init_fly;
    logic              accept;
    logic              done_ok;
    logic              timed_out;

    assign accept    = (state == SEND) && frm_ready;
    assign done_ok   = (state == WAIT) && frm_done;
    assign timed_out = (state == WAIT) && !frm_done && (cnt == TO_LAST);

    assign frm_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign pending   = dirty;

`ifdef AD5676R_INIT_SEQ_EN
    // init_req holds the software-reset frame until PICK takes it; init_fly marks it in flight
    always_ff @(posedge clk or negedge rst_inv) begin
        if (!rst_inv) begin
            init_req <= 1'b1;
            init_fly <= 1'b0;
        end else if ((state == PICK) && init_req) begin
            init_req <= 1'b0;
            init_fly <= 1'b1;
        end else if (done_ok || timed_out) begin
            init_fly <= 1'b0;
        end
    end
`else
    assign init_req = 1'b0;
    assign init_fly = 1'b0;
`endif

    // Search order starts one past the last served channel and wraps
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr;
        idx        = rr;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = rr + 3'(i);
            if (!pick_found && dirty[idx]) begin
                pick_found = 1'b1;
                pick_ch    = idx;
            end
        end
    end

    // Host set is applied last so a write in the clearing cycle keeps the channel dirty
    always_comb begin
        dirty_nxt = dirty;
        if (done_ok && init_fly)
            dirty_nxt = '1;
        if ((state == PICK) && !init_req && pick_found)
            dirty_nxt[pick_ch] = 1'b0;
        if (wr_en)
            dirty_nxt[wr_ch] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (init_req || wr_en || (dirty != '0)) state_nxt = PICK;
            PICK:    state_nxt = (init_req || pick_found) ? SEND : IDLE;
            SEND:    if (frm_ready) state_nxt = WAIT;
            WAIT:    if (frm_done || (cnt == TO_LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_inv) begin
        if (!rst_inv) begin
            state       <= IDLE;
            dirty       <= '0;
            rr          <= 3'd7;
            cnt         <= '0;
            err_timeout <= 1'b0;
            frm_data    <= '0;
            for (int i = 0; i < NUM_CH; i++)
                code[i] <= '0;
        end else begin
            state <= state_nxt;
            dirty <= dirty_nxt;
            if (wr_en)
                code[wr_ch] <= wr_code;
            if (state == PICK) begin
                if (init_req) begin
                    frm_data <= RESET_FRAME;
                end else if (pick_found) begin
                    frm_data <= {4'b0011, 1'b0, pick_ch, code[pick_ch]};
                    rr       <= pick_ch;
                end
            end
            // Counter reaches TO_LAST+1 == DONE_TIMEOUT on the same edge that raises the error
            if (accept)
                cnt <= '0;
            else if ((state == WAIT) && (cnt != 8'hFF))
                cnt <= cnt + 8'd1;
            if (timed_out)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ad5676r_ch_scheduler.sv
// Bench for ad5676r_ch_scheduler: directed scenarios, then random host/writer traffic
// checked against a channel-level model of codes, dirty flags and round-robin order.
module tb_ad5676r_ch_scheduler;

    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst_inv = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = 3'd0;
    logic [15:0] wr_code = 16'h0;
    logic [23:0] frm_data;
    logic        frm_valid;
    logic        frm_ready = 1'b0;
    logic        frm_done = 1'b0;
    logic        busy;
    logic [7:0]  pending;
    logic        err_timeout;

    int tests = 0;
    int failures = 0;

    logic [15:0] mCode [8];
    logic [7:0]  mDirty;
    int          mRr;
    int          found;
    int          pickCh;
    logic [23:0] expFrame;
    logic [23:0] heldData;
    logic        lastValid;
    logic        lastHs;
    logic        lastWrEn;
    logic [2:0]  lastCh;
    logic [15:0] lastCode;
    logic        inFlight;
    int          doneDelay;
    int          hsCount;

    ad5676r_ch_scheduler #(.NUM_CH(8), .DONE_TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_inv(rst_inv),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_code(wr_code),
        .frm_data(frm_data),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .frm_done(frm_done),
        .busy(busy),
        .pending(pending),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs; write and done are single-cycle pulses
    task automatic applyStimulus(input logic en, input logic [2:0] ch, input logic [15:0] cd,
                                 input logic rdy, input logic dn);
        wr_en     = en;
        wr_ch     = ch;
        wr_code   = cd;
        frm_ready = rdy;
        frm_done  = dn;
        tick();
        wr_en    = 1'b0;
        frm_done = 1'b0;
    endtask

    task automatic applyIdle(input logic rdy, input logic dn);
        applyStimulus(1'b0, 3'd0, 16'h0, rdy, dn);
    endtask

    task automatic waitValid(input string tag);
        frm_ready = 1'b0;
        for (int i = 0; i < 40 && !frm_valid; i++)
            tick();
        checkOutput({tag, "_valid"}, 32'(frm_valid), 32'd1);
    endtask

    task automatic serviceFrame(input string tag, input logic [23:0] expected);
        waitValid(tag);
        checkOutput(tag, 32'(frm_data), 32'(expected));
        applyIdle(1'b1, 1'b0);
        applyIdle(1'b0, 1'b1);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst_inv = 1'b1;
`ifdef AD5676R_INIT_SEQ_EN
        tick();
        checkOutput("init_busy", 32'(busy), 32'd1);
        serviceFrame("init_swreset", 24'h600000);
        for (int c = 0; c < 8; c++)
            serviceFrame("init_rewrite", {4'h3, 1'b0, 3'(c), 16'h0000});
        checkOutput("init_pending", 32'(pending), 32'h0);
`else
        tick();
        checkOutput("idle_after_reset", 32'(busy), 32'd0);
`endif
    endtask

    initial begin
        // Reset values
        #12;
        checkOutput("rst_data", 32'(frm_data), 32'h0);
        checkOutput("rst_valid", 32'(frm_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'h0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        releaseReset();

        // Single write with ready tied high
        applyStimulus(1'b1, 3'd3, 16'hABCD, 1'b1, 1'b0);
        checkOutput("single_pending", 32'(pending), 32'h08);
        checkOutput("single_busy", 32'(busy), 32'd1);
        checkOutput("single_valid_early", 32'(frm_valid), 32'd0);
        applyIdle(1'b1, 1'b0);
        checkOutput("single_valid", 32'(frm_valid), 32'd1);
        checkOutput("single_data", 32'(frm_data), 32'h0033ABCD);
        applyIdle(1'b1, 1'b0);
        checkOutput("single_valid_drop", 32'(frm_valid), 32'd0);
        checkOutput("single_pending_clr", 32'(pending), 32'h0);
        applyIdle(1'b0, 1'b1);
        checkOutput("single_idle", 32'(busy), 32'd0);
        checkOutput("single_pending_end", 32'(pending), 32'h0);

        // Round-robin: 6 held in SEND while 1 and 4 arrive
        applyStimulus(1'b1, 3'd6, 16'h6666, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd1, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd4, 16'h4444, 1'b0, 1'b0);
        checkOutput("rr_first_valid", 32'(frm_valid), 32'd1);
        checkOutput("rr_first", 32'(frm_data), 32'h00366666);
        checkOutput("rr_pending", 32'(pending), 32'h12);
        applyIdle(1'b1, 1'b0);
        applyIdle(1'b0, 1'b1);
        checkOutput("rr_gap1", 32'(frm_valid), 32'd0);
        applyIdle(1'b0, 1'b0);
        checkOutput("rr_gap2", 32'(frm_valid), 32'd0);
        applyIdle(1'b0, 1'b0);
        checkOutput("rr_gap3", 32'(frm_valid), 32'd1);
        checkOutput("rr_second", 32'(frm_data), 32'h00311234);
        applyIdle(1'b1, 1'b0);
        applyIdle(1'b0, 1'b1);
        waitValid("rr_third");
        checkOutput("rr_third", 32'(frm_data), 32'h00344444);
        applyIdle(1'b1, 1'b0);
        applyStimulus(1'b1, 3'd0, 16'h0A0A, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7, 16'h7777, 1'b0, 1'b0);
        applyIdle(1'b0, 1'b1);
        serviceFrame("rr_ch7", 24'h377777);
        serviceFrame("rr_ch0", 24'h300A0A);
        checkOutput("rr_done_pending", 32'(pending), 32'h0);

        // Collision: write to the channel being picked keeps it dirty
        applyStimulus(1'b1, 3'd5, 16'h5555, 1'b0, 1'b0);
        applyIdle(1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 16'h1111, 1'b0, 1'b0);
        checkOutput("col_inflight", 32'(frm_data), 32'h00355555);
        applyIdle(1'b1, 1'b0);
        applyIdle(1'b0, 1'b1);
        applyIdle(1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
        checkOutput("col_old_code", 32'(frm_data), 32'h00321111);
        checkOutput("col_dirty_kept", 32'(pending), 32'h04);
        applyIdle(1'b1, 1'b0);
        applyIdle(1'b0, 1'b1);
        serviceFrame("col_new_code", 24'h322222);
        checkOutput("col_pending_end", 32'(pending), 32'h0);

        // Backpressure: 10 cycles without ready, then exactly one handshake
        applyStimulus(1'b1, 3'd0, 16'hBEEF, 1'b0, 1'b0);
        waitValid("bp");
        checkOutput("bp_data", 32'(frm_data), 32'h0030BEEF);
        heldData = frm_data;
        for (int i = 0; i < 10; i++) begin
            applyIdle(1'b0, 1'b0);
            checkOutput("bp_hold_valid", 32'(frm_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(frm_data), 32'(heldData));
        end
        hsCount = 0;
        for (int i = 0; i < 4; i++) begin
            if (frm_valid) hsCount++;
            applyIdle(1'b1, 1'b0);
            checkOutput("bp_after_hs", 32'(frm_valid), 32'd0);
        end
        checkOutput("bp_handshakes", 32'(hsCount), 32'd1);
        applyIdle(1'b0, 1'b1);
        checkOutput("bp_idle", 32'(busy), 32'd0);

        // Timeout with another channel waiting behind it
        applyStimulus(1'b1, 3'd1, 16'h0101, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd6, 16'h0606, 1'b0, 1'b0);
        checkOutput("to_frame", 32'(frm_data), 32'h00310101);
        applyIdle(1'b1, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            checkOutput("to_early", 32'(err_timeout), 32'd0);
            applyIdle(1'b0, 1'b0);
        end
        checkOutput("to_err", 32'(err_timeout), 32'd1);
        checkOutput("to_idle", 32'(busy), 32'd0);
        serviceFrame("to_next", 24'h360606);
        checkOutput("to_sticky", 32'(err_timeout), 32'd1);

        // Reset while a frame is in WAIT
        applyStimulus(1'b1, 3'd3, 16'h3333, 1'b0, 1'b0);
        waitValid("mid");
        applyIdle(1'b1, 1'b0);
        applyStimulus(1'b1, 3'd4, 16'h4040, 1'b0, 1'b0);
        rst_inv = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(frm_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_pending", 32'(pending), 32'h0);
        checkOutput("mid_rst_data", 32'(frm_data), 32'h0);
        checkOutput("mid_rst_err", 32'(err_timeout), 32'd0);
        releaseReset();

        // Random traffic against the channel-level model
        mDirty    = '0;
        mRr       = 7;
        for (int i = 0; i < 8; i++) mCode[i] = 16'h0;
        expFrame  = '0;
        lastValid = frm_valid;
        lastHs    = 1'b0;
        lastWrEn  = 1'b0;
        lastCh    = 3'd0;
        lastCode  = 16'h0;
        inFlight  = 1'b0;
        doneDelay = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (frm_valid && !lastValid) begin
                found  = 0;
                pickCh = 0;
                for (int i = 1; i <= 8; i++) begin
                    if (found == 0 && mDirty[(mRr + i) % 8]) begin
                        found  = 1;
                        pickCh = (mRr + i) % 8;
                    end
                end
                checkOutput("rnd_pick_exists", 32'(found), 32'd1);
                if (found != 0) begin
                    expFrame       = {4'h3, 1'b0, 3'(pickCh), mCode[pickCh]};
                    mDirty[pickCh] = 1'b0;
                    mRr            = pickCh;
                end
                checkOutput("rnd_frame", 32'(frm_data), 32'(expFrame));
            end else if (frm_valid) begin
                checkOutput("rnd_hold", 32'(frm_data), 32'(expFrame));
            end
            if (lastHs)
                checkOutput("rnd_valid_drop", 32'(frm_valid), 32'd0);
            if (lastWrEn) begin
                mCode[lastCh]  = lastCode;
                mDirty[lastCh] = 1'b1;
            end
            checkOutput("rnd_pending", 32'(pending), 32'(mDirty));

            if (lastHs) begin
                inFlight  = 1'b1;
                doneDelay = int'($urandom_range(0, 5));
            end
            frm_done = 1'b0;
            if (inFlight) begin
                if (doneDelay == 0) begin
                    frm_done = 1'b1;
                    inFlight = 1'b0;
                end else begin
                    doneDelay--;
                end
            end else begin
                frm_done = ($urandom_range(0, 15) == 0);
            end
            wr_en     = (cyc < 700) && ($urandom_range(0, 2) == 0);
            wr_ch     = 3'($urandom_range(0, 7));
            wr_code   = 16'($urandom);
            frm_ready = (cyc >= 700) || ($urandom_range(0, 1) == 1);

            lastHs    = frm_valid && frm_ready;
            lastValid = frm_valid;
            lastWrEn  = wr_en;
            lastCh    = wr_ch;
            lastCode  = wr_code;
            tick();
        end
        wr_en    = 1'b0;
        frm_done = 1'b0;
        checkOutput("rnd_drain_pending", 32'(pending), 32'h0);
        checkOutput("rnd_drain_busy", 32'(busy), 32'd0);
        checkOutput("rnd_no_timeout", 32'(err_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ad5676r_ch_scheduler.md
# ad5676r_ch_scheduler

Eight-channel update scheduler for the AD5676R serial DAC path. Holds one 16-bit code per channel written by the host logic, tracks which channels have changed, and issues one 24-bit command frame at a time to the serial writer using round-robin order across changed channels. It sits between the host wire/trigger decode and the DAC serial-writer block, and is the only source of frames to that writer.

## Interface
- `NUM_CH`, 8: channel count; fixed at 8 for the AD5676R, with 3-bit channel address.
- `DONE_TIMEOUT`, 255: number of clk cycles allowed between frame handshake and `frm_done`. Must be at least 1.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_inv` input 1: asynchronous, active-low reset.
- `wr_en` input 1: host write strobe, one cycle.
- `wr_ch` input 3: target channel for `wr_en`.
- `wr_code` input 16: DAC code for `wr_ch`.
- `frm_data` output 24: frame bits. [23:20] is the command, [19:16] is the address, [15:0] is the data.
- `frm_valid` output 1: frame offered to the writer.
- `frm_ready` input 1: writer accepts the frame.
- `frm_done` input 1: one-cycle pulse when the writer finishes the frame (SYNC deasserted).
- `busy` output 1: high in any state other than IDLE.
- `pending` output 8: per-channel dirty flags.
- `err_timeout` output 1: sticky flag for a missing `frm_done`. Only reset clears it.

## Operation
- Storage: `code[0..7]` (16 bits each) and `dirty[7:0]`. Both reset to 0.
- Host write: on `wr_en`, `code[wr_ch]` ← `wr_code` and `dirty[wr_ch]` ← 1. Host writes are accepted in every state.
- Round-robin pointer `rr` (3 bits) resets to 7. The search order starts at `rr+1` and wraps modulo 8.
- States:
  - **IDLE**: if `dirty != 0`, go to PICK.
  - **PICK**: select the first dirty channel `n` in search order. Latch `frm_data` = {4'b0011, 1'b0, n, code[n]} (command 0x3, write and update channel n). Clear `dirty[n]`. Set `rr` ← n. Go to SEND.
  - **SEND**: `frm_valid` = 1 and `frm_data` is held stable. When `frm_valid && frm_ready`, go to WAIT, and the timeout counter loads 0.
  - **WAIT**: when `frm_done` arrives, go to IDLE. If the counter reaches `DONE_TIMEOUT` first, set `err_timeout` and go to IDLE.
- Simultaneous write and clear: if `wr_en` targets `n` in the same PICK cycle that clears `dirty[n]`, the set wins. `dirty[n]` stays 1, and the new code goes out in a later frame. The latched frame carries the old code.
- A write during SEND or WAIT to the channel in flight does not change `frm_data`. It only sets `dirty`.
- `frm_done` outside WAIT is ignored. `frm_ready` outside SEND is ignored.
- Reset mid-operation: all state returns to reset values immediately. `frm_valid` drops asynchronously, and any in-flight frame is abandoned.

## Timing
- Reset values: `frm_data` = 0, `frm_valid` = 0, `busy` = 0, `pending` = 0, `err_timeout` = 0.
- Latency: a `wr_en` in cycle T to an idle block produces `dirty` in T+1, PICK in T+1, and `frm_valid` = 1 from T+2.
- `frm_valid` is registered and stays high until the handshake cycle. It falls in the cycle after acceptance.
- The minimum frame-to-frame spacing is `frm_done` → IDLE → PICK → SEND, so there are 3 cycles from `frm_done` to the next `frm_valid`.
- The timeout counter is 8 bits (wide enough for the default 255) and saturates. `err_timeout` sets in the cycle the counter equals `DONE_TIMEOUT`.

## Configuration
- `AD5676R_INIT_SEQ_EN`: when defined, the first frame after reset release is the software reset frame {4'b0110, 4'b0000, 16'h0000}. That frame uses the normal SEND/WAIT handshake. After its `frm_done`, all eight `dirty` bits are set, so every held code (0 after reset) is rewritten starting at channel 0. `busy` = 1 from the first clk after reset release. If the macro is undefined, the block idles after reset until the first `wr_en`.

## Test plan
- Single write: `wr_ch`=3, `wr_code`=16'hABCD with `frm_ready` tied 1 → `frm_data`=24'h33ABCD valid for 1 cycle. After `frm_done`, `busy`=0 and `pending`=0.
- Round-robin: write channels 6, 1, 4 in consecutive cycles while the writer is held busy on channel 6 → the following frames address 1 and then 4. After a later write to 0 and 7, the order is 7 then 0.
- Collision: `wr_en` to channel 2 (16'h1111) while in flight, then 16'h2222 in the PICK cycle for channel 2 → that frame carries 16'h1111, and a second frame carries 16'h2222.
- Backpressure: `frm_ready` = 0 for 10 cycles → `frm_valid` stays 1 and `frm_data` stays constant. On ready, exactly one handshake occurs.
- Timeout: suppress `frm_done` with `DONE_TIMEOUT`=20 → `err_timeout` rises 20 cycles after acceptance, the block returns to IDLE, and the next dirty channel is still served.
- Reset mid-WAIT, with `AD5676R_INIT_SEQ_EN` defined: all outputs return to reset values. After release, the first frame is 24'h600000, followed by frames 24'h300000 through 24'h370000.
